// File: rtl/rv_core_pkg.sv
// rtl/rv_core_pkg.sv - shared constants and types for the RV32I front end
//
// Purpose: opcode5 values, fetch/decode state encoding, instruction field
// bit positions and the decoded-operand bundle passed from decoder to fetch.
// Ports: none (package).
package rv_core_pkg;

    localparam logic [4:0] OP_LUI   = 5'h0D;
    localparam logic [4:0] OP_AUIPC = 5'h05;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;

    localparam int QUAD_MSB    = 1;
    localparam int QUAD_LSB    = 0;
    localparam int OPCODE5_MSB = 6;
    localparam int OPCODE5_LSB = 2;
    localparam int RD_MSB      = 11;
    localparam int RD_LSB      = 7;
    localparam int RS1_MSB     = 19;
    localparam int RS1_LSB     = 15;
    localparam int IMM20_MSB   = 31;
    localparam int IMM20_LSB   = 12;

    // 32-bit encodings always carry 2'b11 in the low two bits.
    localparam logic [1:0] QUAD_32BIT = 2'b11;

    localparam logic [31:0] HIGH_IMPEDANCE = 32'bz;

    typedef struct packed {
        logic [31:0] immediate20_utype;
        logic [4:0]  opcode5;
        logic [4:0]  rd_index;
        logic [4:0]  rs1_index;
        logic        enable_lui;
        logic        enable_auipc;
        logic        illegal;
    } decode_t;

endpackage

// File: rtl/utype_decoder.sv
// rtl/utype_decoder.sv - combinational U-type instruction field decoder
//
// Purpose: splits one instruction word into the operand bus fields and the
// one-hot lui/auipc unit enables.
// Ports:
//   instr   in  32  instruction word
//   decoded out     decode_t bundle (immediate, indices, opcode5, enables, illegal)
module utype_decoder
    import rv_core_pkg::*;
(
    input  logic [31:0] instr,
    output decode_t     decoded
);

    always_comb begin
        decoded                   = '0;
        decoded.immediate20_utype = {instr[IMM20_MSB:IMM20_LSB], 12'b0};
        decoded.opcode5           = instr[OPCODE5_MSB:OPCODE5_LSB];
        decoded.rd_index          = instr[RD_MSB:RD_LSB];
        decoded.rs1_index         = instr[RS1_MSB:RS1_LSB];
        decoded.illegal           = (instr[QUAD_MSB:QUAD_LSB] != QUAD_32BIT);
        // An illegal word is still issued, but must not fire any U-type unit.
        decoded.enable_lui        = !decoded.illegal && (decoded.opcode5 == OP_LUI);
        decoded.enable_auipc      = !decoded.illegal && (decoded.opcode5 == OP_AUIPC);
    end

endmodule

// File: rtl/instruction_fetch_decode.sv
// rtl/instruction_fetch_decode.sv - RV32I fetch/decode front end with PC and redirect
//
// Purpose: holds the fetch PC, issues one instruction-memory request at a
// time, registers the decoded word and presents it to execute until it is
// not stalled. Redirects from execute restart fetch at a new address.
// Ports:
//   clock, reset                    core clock, synchronous active-high reset
//   imem_req/imem_addr              fetch request and word-aligned address
//   imem_ready/imem_rdata           request accepted, instruction word same cycle
//   stall                           execute busy, hold issued instruction
//   redirect_valid/redirect_pc      control transfer from execute
//   issue_valid, pc                 issued instruction valid and its address
//   immediate20_utype, opcode5,
//   rd_index, rs1_index             decoded operand fields
//   enable_lui, enable_auipc        U-type unit enables
//   illegal                         issued word is not a 32-bit encoding
module instruction_fetch_decode
    import rv_core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        issue_valid,
    output logic [31:0] pc,
    output logic [31:0] immediate20_utype,
    output logic [4:0]  opcode5,
    output logic [4:0]  rd_index,
    output logic [4:0]  rs1_index,
    output logic        enable_lui,
    output logic        enable_auipc,
    output logic        illegal
);

    logic [1:0]  state;
    logic [31:0] fetch_pc;
    logic [31:0] pc_q;
    decode_t     dec_now;
    decode_t     dec_q;
    logic [31:0] redirect_target;

    utype_decoder u_decoder (
        .instr   (imem_rdata),
        .decoded (dec_now)
    );

    // Low address bits are forced to zero so fetch stays word aligned.
    assign redirect_target = redirect_pc & ~32'h3;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_PC;
            pc_q     <= '0;
            dec_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_REQ;
                end
                ST_REQ: begin
                    // Redirect wins: a word accepted in this same cycle belongs
                    // to the old path and is dropped.
                    if (redirect_valid) begin
                        fetch_pc <= redirect_target;
                    end else if (imem_ready) begin
                        pc_q  <= fetch_pc;
                        dec_q <= dec_now;
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (redirect_valid) begin
                        fetch_pc <= redirect_target;
                        state    <= ST_REQ;
                    end else if (!stall) begin
                        fetch_pc <= pc_q + 32'd4;
                        state    <= ST_REQ;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs depend only on registered state, never directly on inputs.
    assign imem_req          = (state == ST_REQ);
    assign imem_addr         = imem_req ? fetch_pc : '0;
    assign issue_valid       = (state == ST_ISSUE);
    assign pc                = pc_q;
    assign immediate20_utype = dec_q.immediate20_utype;
    assign opcode5           = dec_q.opcode5;
    assign rd_index          = dec_q.rd_index;
    assign rs1_index         = dec_q.rs1_index;
    assign enable_lui        = dec_q.enable_lui & issue_valid;
    assign enable_auipc      = dec_q.enable_auipc & issue_valid;
    assign illegal           = dec_q.illegal & issue_valid;

endmodule

// File: tb/tb_instruction_fetch_decode.sv
// tb/tb_instruction_fetch_decode.sv - scoreboard bench for instruction_fetch_decode
module tb_instruction_fetch_decode;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        issue_valid;
    logic [31:0] pc;
    logic [31:0] immediate20_utype;
    logic [4:0]  opcode5;
    logic [4:0]  rd_index;
    logic [4:0]  rs1_index;
    logic        enable_lui;
    logic        enable_auipc;
    logic        illegal;

    always #5 clock = ~clock;

    instruction_fetch_decode #(.RESET_PC(32'h0000_0100)) dut (
        .clock             (clock),
        .reset             (reset),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_ready        (imem_ready),
        .imem_rdata        (imem_rdata),
        .stall             (stall),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .issue_valid       (issue_valid),
        .pc                (pc),
        .immediate20_utype (immediate20_utype),
        .opcode5           (opcode5),
        .rd_index          (rd_index),
        .rs1_index         (rs1_index),
        .enable_lui        (enable_lui),
        .enable_auipc      (enable_auipc),
        .illegal           (illegal)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [2:0]  flags; // {lui, auipc, illegal}
    } issue_t;

    issue_t      exp_q[$];
    logic [31:0] addr_q[$];
    int          tests = 0;
    int          fails = 0;
    logic        prev_iv = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic issue_t mk(input logic [31:0] p, input logic [31:0] imm,
                                  input logic [4:0] op, input logic [4:0] rd,
                                  input logic [4:0] rs1, input logic [2:0] flags);
        issue_t e;
        e.pc = p; e.imm = imm; e.op = op; e.rd = rd; e.rs1 = rs1; e.flags = flags;
        return e;
    endfunction

    // Monitor: pops expected accepts and issues whenever the DUT presents them.
    always @(negedge clock) begin
        if (reset) begin
            prev_iv <= 1'b0;
        end else begin
            if (imem_req && imem_ready && !redirect_valid) begin
                if (addr_q.size() == 0) check("unexpected_accept", imem_addr, 32'hxxxx_xxxx);
                else check("accept_addr", imem_addr, addr_q.pop_front());
            end
            if (issue_valid && !prev_iv) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_issue_pc", pc, 32'hxxxx_xxxx);
                end else begin
                    issue_t e;
                    e = exp_q.pop_front();
                    check("issue_pc", pc, e.pc);
                    check("issue_imm", immediate20_utype, e.imm);
                    check("issue_opcode5", {27'd0, opcode5}, {27'd0, e.op});
                    check("issue_rd", {27'd0, rd_index}, {27'd0, e.rd});
                    check("issue_rs1", {27'd0, rs1_index}, {27'd0, e.rs1});
                    check("issue_flags", {29'd0, enable_lui, enable_auipc, illegal}, {29'd0, e.flags});
                end
            end
            if (!issue_valid)
                check("idle_flags", {29'd0, enable_lui, enable_auipc, illegal}, 32'd0);
            prev_iv <= issue_valid;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Waits for a request, holds ready low for wait_n cycles (address must stay
    // put), then accepts word and queues the expected issue.
    task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] word,
                         input int wait_n, input issue_t e);
        int n;
        n = 0;
        while (!imem_req && n < 20) begin
            step();
            n++;
        end
        if (!imem_req) begin
            check("req_timeout", 32'd0, 32'd1);
            return;
        end
        imem_ready = 1'b0;
        repeat (wait_n) begin
            check("addr_stable", imem_addr, exp_addr);
            step();
        end
        imem_ready = 1'b1;
        imem_rdata = word;
        addr_q.push_back(exp_addr);
        exp_q.push_back(e);
        step();
        imem_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; imem_ready = 1'b0; imem_rdata = '0; stall = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        repeat (3) @(posedge clock);
        #1;
        // Reset values while reset held.
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        check("rst_issue", {31'd0, issue_valid}, 32'd0);
        check("rst_pc", pc, 32'd0);
        check("rst_imm", immediate20_utype, 32'd0);
        reset = 1'b0;

        // Back-to-back fetch with ready always high: 2 cycles per instruction.
        imem_ready = 1'b1;
        imem_rdata = 32'h0000_0013;
        for (int k = 0; k < 3; k++) begin
            addr_q.push_back(32'h100 + 32'(4 * k));
            exp_q.push_back(mk(32'h100 + 32'(4 * k), 32'h0, 5'h04, 5'd0, 5'd0, 3'b000));
        end
        for (int i = 0; i < 7; i++) begin
            check("peak_req", {31'd0, imem_req}, {31'd0, 1'(i % 2)});
            check("peak_issue", {31'd0, issue_valid}, {31'd0, 1'(i > 0 && i % 2 == 0)});
            if (i % 2 == 1) check("peak_addr", imem_addr, 32'h100 + 32'(4 * ((i - 1) / 2)));
            if (i == 6) imem_ready = 1'b0;
            step();
        end

        // U-type decode.
        fetch(32'h10C, 32'h1234_5297, 0, mk(32'h10C, 32'h1234_5000, 5'h05, 5'd5, 5'd8, 3'b010));
        fetch(32'h110, 32'hABCD_E0B7, 0, mk(32'h110, 32'hABCD_E000, 5'h0D, 5'd1, 5'd27, 3'b100));

        // Ready low for 3 cycles, then stall 2 cycles in ISSUE.
        fetch(32'h114, 32'h0000_0013, 3, mk(32'h114, 32'h0, 5'h04, 5'd0, 5'd0, 3'b000));
        stall = 1'b1;
        check("stall_hold0", {pc[30:0], issue_valid}, {31'h114, 1'b1});
        step();
        check("stall_hold1", {pc[30:0], issue_valid}, {31'h114, 1'b1});
        step();
        stall = 1'b0;
        check("stall_hold2", {pc[30:0], issue_valid}, {31'h114, 1'b1});
        check("stall_no_req", {31'd0, imem_req}, 32'd0);
        step();
        check("after_stall_req", {31'd0, imem_req}, 32'd1);
        check("after_stall_addr", imem_addr, 32'h118);

        // Redirect with a same-cycle response: response dropped.
        imem_ready = 1'b1; imem_rdata = 32'hABCD_E0B7;
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        step();
        imem_ready = 1'b0; redirect_valid = 1'b0;
        check("redir_req", {31'd0, imem_req}, 32'd1);
        check("redir_addr", imem_addr, 32'h200);
        check("redir_no_issue", {31'd0, issue_valid}, 32'd0);

        // Illegal words: all-zero, and lui opcode with bad low bits.
        fetch(32'h200, 32'h0000_0000, 0, mk(32'h200, 32'h0, 5'h00, 5'd0, 5'd0, 3'b001));
        step();
        fetch(32'h204, 32'h0000_0034, 0, mk(32'h204, 32'h0, 5'h0D, 5'd0, 5'd0, 3'b001));

        // Redirect in ISSUE beats stall and squashes the issued word.
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        stall = 1'b0; redirect_valid = 1'b0;
        check("squash_issue", {31'd0, issue_valid}, 32'd0);
        check("squash_addr", imem_addr, 32'hFFFF_FFFC);

        // PC wrap from the top word.
        fetch(32'hFFFF_FFFC, 32'hABCD_E0B7, 0, mk(32'hFFFF_FFFC, 32'hABCD_E000, 5'h0D, 5'd1, 5'd27, 3'b100));
        step();
        check("wrap_req", {31'd0, imem_req}, 32'd1);
        check("wrap_addr", imem_addr, 32'h0);

        // Reset while REQ with ready low.
        reset = 1'b1;
        step();
        check("midrst_req", {31'd0, imem_req}, 32'd0);
        check("midrst_addr", imem_addr, 32'd0);
        check("midrst_issue", {31'd0, issue_valid}, 32'd0);
        check("midrst_pc", pc, 32'd0);
        check("midrst_imm", immediate20_utype, 32'd0);
        check("midrst_fields", {17'd0, opcode5, rd_index, rs1_index}, 32'd0);
        check("midrst_flags", {29'd0, enable_lui, enable_auipc, illegal}, 32'd0);
        reset = 1'b0;
        check("restart_idle", {31'd0, imem_req}, 32'd0);
        step();
        check("restart_req", {31'd0, imem_req}, 32'd1);
        check("restart_addr", imem_addr, 32'h100);
        fetch(32'h100, 32'h1234_5297, 0, mk(32'h100, 32'h1234_5000, 5'h05, 5'd5, 5'd8, 3'b010));
        step();
        step();

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("addr_q_drained", 32'(addr_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_decode.md
# instruction_fetch_decode

Front-end stage of the minimum RV32I core: holds the program counter, fetches one instruction at a time over a simple request/ready handshake, and decodes it into the operand bus consumed by the execute units. It produces `pc`, `immediate20_utype`, register indices and per-unit enables, so the U-type execute units (`lui`, `auipc`) are driven only by this block. Control redirects (jumps/branches) come back from execute and restart fetch.

## Interface
- `RESET_PC`, 32'h0000_0000, address of first fetch after reset
- `clock`  in  1  single core clock, all state on rising edge
- `reset`  in  1  synchronous, active-high
- `imem_req`  out  1  fetch request, held until accepted
- `imem_addr`  out  32  fetch address, word aligned, stable while `imem_req`=1
- `imem_ready`  in  1  request accepted; `imem_rdata` valid same cycle
- `imem_rdata`  in  32  instruction word
- `stall`  in  1  execute busy; hold issued instruction
- `redirect_valid`  in  1  control transfer from execute
- `redirect_pc`  in  32  target; bits [1:0] ignored (forced 0)
- `issue_valid`  out  1  decoded outputs valid this cycle
- `pc`  out  32  address of issued instruction
- `immediate20_utype`  out  32  {instr[31:12], 12'b0}
- `opcode5`  out  5  instr[6:2]
- `rd_index`, `rs1_index`  out  5 each  instr[11:7], instr[19:15]
- `enable_lui`, `enable_auipc`  out  1 each  one-hot unit enables, qualified by `issue_valid`
- `illegal`  out  1  issued word has instr[1:0] != 2'b11

## Operation
- States: IDLE, REQ, ISSUE.
- IDLE: entered on reset; `fetch_pc`=RESET_PC; all outputs 0. Always -> REQ next cycle.
- REQ: `imem_req`=1, `imem_addr`=`fetch_pc`. On `imem_ready`: latch word, decode, latch `pc`=`fetch_pc`, -> ISSUE. Without ready: stay, address unchanged.
- ISSUE: `issue_valid`=1, decoded outputs registered and stable. If `stall`=1: stay, outputs held. Else `fetch_pc`=`pc`+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0), -> REQ.
- Redirect (any non-IDLE state, highest priority over `imem_ready` and `stall`): `fetch_pc`={`redirect_pc`[31:2],2'b00}, -> REQ; a response accepted in the same cycle is discarded; an instruction in ISSUE is squashed (`issue_valid` low next cycle).
- Decode: opcode5 5'h0D -> `enable_lui`; 5'h05 -> `enable_auipc`; any other -> both low (other units decode `opcode5`). `illegal`=1 forces both enables low; word still issued.
- Enables and `illegal` are 0 whenever `issue_valid`=0.
- Reset mid-operation: next cycle IDLE, all outputs 0, pending request dropped.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=0, `issue_valid`=0, `pc`=0, `immediate20_utype`=0, indices/opcode 0, enables 0, `illegal`=0.
- First `imem_req` in cycle 1 after `reset` falls (IDLE occupies cycle 0).
- Accept at cycle N -> `issue_valid` at N+1 -> next `imem_req` at N+2 (no stall): 2 cycles/instruction peak.
- Redirect at cycle N -> `imem_req` with new address at N+1.
- All outputs registered; no combinational path from inputs to outputs.

## Structure
- Shared package `rv_core_pkg`: opcode5 constants (OP_LUI=5'h0D, OP_AUIPC=5'h05), state encoding, instruction field bit ranges, `HIGH_IMPEDANCE` shared constant.
- Sub-module `utype_decoder`: combinational word -> immediate, indices, opcode5, enables, illegal; instantiated once, outputs registered in parent.

## Test plan
- Reset, RESET_PC=32'h100, ready always 1 -> `imem_addr` 0x100, 0x104, 0x108 on alternate cycles; `pc` matches on each `issue_valid`.
- Word 32'h12345297 (auipc x5) -> `enable_auipc`=1, `immediate20_utype`=32'h12345000, `rd_index`=5; word 32'hABCDE0B7 (lui x1) -> `enable_lui`=1, imm 32'hABCDE000.
- `imem_ready` low 3 cycles then high -> `imem_addr` stable for 4 cycles, single issue; `stall` high 2 cycles in ISSUE -> outputs held 3 cycles, then fetch pc+4.
- `redirect_valid` with `redirect_pc`=32'h203 in the same cycle as `imem_ready` -> response dropped, next request at 32'h200, no issue of dropped word.
- Word 32'h00000000 -> `illegal`=1, both enables 0; `pc`=32'hFFFF_FFFC issued -> next fetch address 32'h0.
- `reset` asserted while in REQ with ready low -> next cycle all outputs 0, fetch restarts at RESET_PC.
